// File: rtl/bp_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sequencer
// Brief    : Queues resolved branches, serialises them onto the predictor
//            update port, keeps saturating stats and offers a drain handshake.
// Revision : 1.0
// ============================================================================
module bp_update_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             res_valid,
   input  logic [9:0]       res_pc,
   input  logic             res_taken,
   input  logic             res_predicted,
   output logic             res_ready,
   input  logic             hold,
   input  logic             drain_req,
   output logic             drain_done,
   output logic             upd_we,
   output logic [9:0]       upd_pc,
   output logic             upd_taken,
   output logic             mispredict,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);
   localparam int c_ptr_w = $clog2(DEPTH);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [10:0]        r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic [CNT_W-1:0]   r_branch_cnt;
   logic [CNT_W-1:0]   r_mispred_cnt;
   logic               r_mispredict;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_miss;

   // DEPTH is a power of two, so the occupancy MSB alone marks a full FIFO.
   assign w_empty   = (r_count == '0);
   assign w_full    = r_count[c_ptr_w];
   assign res_ready = !w_full && (r_state == RUN);
   assign w_push    = res_valid && res_ready;
   assign w_pop     = !w_empty && !(hold && (r_state == RUN));
   assign w_miss    = w_push && (res_taken != res_predicted);

   assign upd_we      = w_pop;
   assign upd_pc      = w_empty ? 10'd0 : r_mem[r_rd_ptr][10:1];
   assign upd_taken   = !w_empty && r_mem[r_rd_ptr][0];
   assign drain_done  = (r_state == DONE);
   assign mispredict  = r_mispredict;
   assign branch_cnt  = r_branch_cnt;
   assign mispred_cnt = r_mispred_cnt;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {res_pc, res_taken};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RUN;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
         r_mispredict  <= 1'b0;
      end else begin
         r_mispredict <= w_miss;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end

         if (clr_stats) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
         end else begin
            if (w_push && (r_branch_cnt != '1)) begin
               r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_miss && (r_mispred_cnt != '1)) begin
               r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
         end

         case (r_state)
            RUN: begin
               if (drain_req) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // Pops are unconditional here, so occupancy <= 1 empties this edge.
               if (r_count[c_ptr_w:1] == '0) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= drain_req ? DRAIN : RUN;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_bp_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_sequencer
// Brief    : Randomised scoreboard bench for bp_update_sequencer.
// Revision : 1.0
// ============================================================================
module tb_bp_update_sequencer;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             res_valid;
   logic [9:0]       res_pc;
   logic             res_taken;
   logic             res_predicted;
   logic             res_ready;
   logic             hold;
   logic             drain_req;
   logic             drain_done;
   logic             upd_we;
   logic [9:0]       upd_pc;
   logic             upd_taken;
   logic             mispredict;
   logic             clr_stats;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   int errors = 0;
   int checks = 0;

   logic [10:0] exp_q[$];
   logic [10:0] mon_e;

   typedef enum {M_RUN, M_DRAIN, M_DONE} mode_t;
   mode_t m_mode = M_RUN;
   int    m_occ  = 0;
   int    m_bcnt = 0;
   int    m_mcnt = 0;
   bit    m_mis  = 1'b0;
   bit    m_live = 1'b0;
   int    nocc;
   bit    acc, we, rdy;

   bp_update_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
      .res_predicted(res_predicted), .res_ready(res_ready),
      .hold(hold), .drain_req(drain_req), .drain_done(drain_done),
      .upd_we(upd_we), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .mispredict(mispredict), .clr_stats(clr_stats),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write the DUT issues must match the oldest outstanding accept.
   always @(negedge clk) begin
      if (m_live) begin
         if (upd_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got write pc=%0h expected no write at %0t", upd_pc, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("upd_pc", 32'(upd_pc), 32'(mon_e[10:1]));
               check("upd_taken", 32'(upd_taken), 32'(mon_e[0]));
            end
         end else if (exp_q.size() == 0) begin
            check("idle_pc", 32'(upd_pc), 32'd0);
            check("idle_taken", 32'(upd_taken), 32'd0);
         end
      end
   end

   // Reference model: checks control outputs, then advances across the next edge.
   always @(negedge clk) begin
      #1;
      rdy = (m_occ < DEPTH) && (m_mode == M_RUN);
      we  = (m_occ > 0) && !(hold && (m_mode == M_RUN));
      if (m_live) begin
         check("res_ready", 32'(res_ready), 32'(rdy));
         check("upd_we", 32'(upd_we), 32'(we));
         check("drain_done", 32'(drain_done), 32'(m_mode == M_DONE));
         check("mispredict", 32'(mispredict), 32'(m_mis));
         check("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
         check("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
      end
      if (rst) begin
         exp_q.delete();
         m_occ  = 0;
         m_mode = M_RUN;
         m_bcnt = 0;
         m_mcnt = 0;
         m_mis  = 1'b0;
         m_live = 1'b1;
      end else if (m_live) begin
         acc = res_valid && rdy;
         if (acc) exp_q.push_back({res_pc, res_taken});
         m_mis = acc && (res_taken != res_predicted);
         if (clr_stats) begin
            m_bcnt = 0;
            m_mcnt = 0;
         end else begin
            if (acc)   m_bcnt = (m_bcnt < CNT_MAX) ? m_bcnt + 1 : CNT_MAX;
            if (m_mis) m_mcnt = (m_mcnt < CNT_MAX) ? m_mcnt + 1 : CNT_MAX;
         end
         nocc = m_occ + int'(acc) - int'(we);
         case (m_mode)
            M_RUN:   if (drain_req) m_mode = M_DRAIN;
            M_DRAIN: if (nocc == 0) m_mode = M_DONE;
            default: m_mode = drain_req ? M_DRAIN : M_RUN;
         endcase
         m_occ = nocc;
      end
   end

   task automatic drive(input bit v, input logic [9:0] pc, input bit t, input bit p,
                        input bit h, input bit d, input bit c, input bit r = 1'b0);
      res_valid = v; res_pc = pc; res_taken = t; res_predicted = p;
      hold = h; drain_req = d; clr_stats = c; rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bit d_lvl;
      rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
      res_predicted = 1'b0; hold = 1'b0; drain_req = 1'b0; clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single mispredicted branch
      drive(1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Fill under hold, fifth entry stalls until space frees
      for (int i = 1; i <= 5; i++) drive(1'b1, 10'(i), i[0], 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Back-to-back streaming across pointer wrap
      for (int i = 0; i < 10; i++)
         drive(1'b1, 10'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
      idle(3);

      // Drain while frozen; offers during drain must be refused
      for (int i = 0; i < 3; i++)
         drive(1'b1, 10'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         drive(1'b1, 10'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
      idle(6);

      // Counter saturation, then clear coinciding with an accept
      for (int i = 0; i < 20; i++) drive(1'b1, 10'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 10'h3ff, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);

      // Held drain request cycles DRAIN/DONE
      drive(1'b1, 10'h0aa, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 10'h0bb, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (8) drive(1'b1, 10'h0cc, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(3);

      // Reset while draining with entries queued
      for (int i = 0; i < 3; i++)
         drive(1'b1, 10'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(5);

      // Random traffic
      d_lvl = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) d_lvl = !d_lvl;
         drive($urandom_range(0, 9) < 7, 10'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 9) < 3, d_lvl, $urandom_range(0, 49) == 0,
               $urandom_range(0, 199) == 0);
      end

      idle(12);
      check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
